move_cmd_gen: RTL and testbench
===============================

MOVE_CMD_GEN -- requirements
Module: move_cmd_gen

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, the number of consecutive stable synchronized cycles required before a move is accepted (legal range 1..255).
REQ-002 SHALL have parameter CNT_W, default $clog2(DEBOUNCE_CYCLES+1), the width of the debounce counter.
REQ-003 SHALL have port clock, input, 1: the single clock; all flops update on its rising edge.
REQ-004 SHALL have port R, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have ports btn_n, btn_s, btn_e, btn_w, input, 1 each: raw asynchronous direction buttons, active-high.
REQ-006 SHALL have ports win and d, input, 1 each: game-over status from the game block (player won, player dead).
REQ-007 SHALL have ports n, s, e, w, output, 1 each: one-cycle move pulses to the game block, at most one high in any cycle.
REQ-008 SHALL have port move_count, output, 8: number of accepted moves, saturating.
REQ-009 SHALL have port locked, output, 1: sticky game-over lockout flag.

Function
REQ-010 SHALL pass each btn_* through a 2-flop synchronizer; only the synchronized vector sb[3:0] (order n,s,e,w) feeds the FSM.
REQ-011 SHALL implement FSM states IDLE, DEBOUNCE, ISSUE, HOLD, REJECT.
REQ-012 In IDLE: sb one-hot -> latch dir=sb, cnt=0, go to DEBOUNCE; sb has 2 or more bits set -> REJECT; sb==0 -> stay in IDLE.
REQ-013 In DEBOUNCE: sb!=dir -> IDLE without pulse; sb==dir and cnt==DEBOUNCE_CYCLES-1 -> ISSUE; otherwise cnt+1.
REQ-014 ISSUE SHALL last exactly one cycle, then go to HOLD.
REQ-015 In HOLD: sb==0 -> IDLE; otherwise stay in HOLD, so a held button yields exactly one pulse.
REQ-016 In REJECT: no pulses; sb==0 -> IDLE.
REQ-017 n/s/e/w SHALL be decoded from registered state: the output for dir is high only while state==ISSUE and locked==0.
REQ-018 Latency: raw button stable high from edge 0 -> pulse high in the cycle following edge DEBOUNCE_CYCLES+2; 6 with the default.
REQ-019 move_count SHALL increment by 1 on each ISSUE cycle with locked==0, and SHALL hold at 255 (no wrap).
REQ-020 locked SHALL set on the edge after win|d is sampled high and stay set until R.
REQ-021 If win|d is sampled high in the same cycle as ISSUE, the pulse SHALL still issue (locked is still 0), and locked SHALL set on that edge.
REQ-022 While locked, the FSM SHALL keep running, but no pulse is emitted and move_count is frozen.

Reset
REQ-023 On R sampled high: state=IDLE, cnt=0, dir=0, synchronizer flops=0, move_count=0, locked=0, n/s/e/w=0 from the next cycle.
REQ-024 R asserted mid-DEBOUNCE or during ISSUE SHALL abort the move: no pulse after the reset edge and no move_count increment.
REQ-025 R SHALL take priority over every other input in the same cycle.

Structure
REQ-026 State enum mv_state_t and the direction index constants DIR_N=3, DIR_S=2, DIR_E=1, DIR_W=0 SHALL live in shared package game_pkg.
REQ-027 The synchronizer SHALL be sub-module btn_sync, parameterized by width and instantiated once with width 4.
REQ-028 Outputs n/s/e/w SHALL connect directly to the matching game inputs; win and d SHALL be fed back from the game outputs.

Verification
REQ-029 Reset, then btn_e held high from edge 0 -> e high for exactly one cycle after edge 6, move_count=1, no further pulse while held.
REQ-030 btn_n glitch high for 3 cycles (shorter than needed) -> no pulse, move_count=0, FSM back in IDLE.
REQ-031 btn_n and btn_w pressed together -> REJECT, no pulse; release both, then press btn_s -> s pulse only.
REQ-032 Drive d=1, then btn_w held -> w stays 0, locked=1, move_count unchanged; R -> locked=0, move_count=0.
REQ-033 256 debounced press/release cycles -> move_count saturates at 255; no overflow to 0.
REQ-034 R asserted on the cycle before the expected pulse -> no pulse, all outputs 0 after the reset edge.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-side definitions: move-generator FSM states, direction
// bit positions and the move counter ceiling.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        ISSUE,
        HOLD,
        REJECT
    } mv_state_t;

    // Bit positions inside the {n, s, e, w} button / direction vector.
    localparam int DIR_N = 3;
    localparam int DIR_S = 2;
    localparam int DIR_E = 1;
    localparam int DIR_W = 0;

    localparam logic [7:0] MOVE_COUNT_MAX = 8'd255;

    function automatic logic is_one_hot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/move_cmd_gen_btn_sync.sv
// Two-flop synchronizer for a vector of independent asynchronous inputs.
module btn_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             R,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] meta_d;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
    end

    // NOTE: non-blocking assignments let both stages sample their old inputs
    // on the same edge; blocking ones would collapse the chain to one flop.
    always_ff @(posedge clock) begin
        if (R) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q;

endmodule

// File: rtl/move_cmd_gen.sv
// Turns raw direction buttons into debounced single-cycle move pulses,
// counts accepted moves and locks out further moves once the game is over.
module move_cmd_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clock,
    input  logic       R,
    input  logic       btn_n,
    input  logic       btn_s,
    input  logic       btn_e,
    input  logic       btn_w,
    input  logic       win,
    input  logic       d,
    output logic       n,
    output logic       s,
    output logic       e,
    output logic       w,
    output logic [7:0] move_count,
    output logic       locked
);

    import game_pkg::*;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       btn_raw;
    logic [3:0]       sb;

    mv_state_t        state_q;
    mv_state_t        state_d;
    logic [3:0]       dir_q;
    logic [3:0]       dir_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [7:0]       move_count_q;
    logic [7:0]       move_count_d;
    logic             locked_q;
    logic             locked_d;
    logic             issue_ok;

    assign btn_raw = {btn_n, btn_s, btn_e, btn_w};

    btn_sync #(
        .WIDTH(4)
    ) u_btn_sync (
        .clock(clock),
        .R    (R),
        .din  (btn_raw),
        .dout (sb)
    );

    // A move only counts while the game is still running.
    assign issue_ok = (state_q == ISSUE) && !locked_q;

    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        cnt_d        = cnt_q;
        move_count_d = move_count_q;
        locked_d     = locked_q | win | d;

        if (issue_ok && (move_count_q != MOVE_COUNT_MAX)) begin
            move_count_d = move_count_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (is_one_hot(sb)) begin
                    dir_d   = sb;
                    cnt_d   = '0;
                    state_d = DEBOUNCE;
                end else if (sb != 4'd0) begin
                    state_d = REJECT;
                end
            end
            DEBOUNCE: begin
                if (sb != dir_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ISSUE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ISSUE: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (sb == 4'd0) begin
                    state_d = IDLE;
                end
            end
            REJECT: begin
                if (sb == 4'd0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (R) begin
            state_q      <= IDLE;
            dir_q        <= '0;
            cnt_q        <= '0;
            move_count_q <= '0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            cnt_q        <= cnt_d;
            move_count_q <= move_count_d;
            locked_q     <= locked_d;
        end
    end

    assign n          = issue_ok & dir_q[DIR_N];
    assign s          = issue_ok & dir_q[DIR_S];
    assign e          = issue_ok & dir_q[DIR_E];
    assign w          = issue_ok & dir_q[DIR_W];
    assign move_count = move_count_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_move_cmd_gen.sv
// Randomized scoreboard bench for move_cmd_gen: press-level reference model
// predicts pulse direction and cycle, a negedge monitor checks the DUT.
module tb_move_cmd_gen;

    localparam int DEB = 4;

    logic       clock = 1'b0;
    logic       R = 1'b1;
    logic       btn_n = 1'b0;
    logic       btn_s = 1'b0;
    logic       btn_e = 1'b0;
    logic       btn_w = 1'b0;
    logic       win = 1'b0;
    logic       d = 1'b0;
    logic       n;
    logic       s;
    logic       e;
    logic       w;
    logic [7:0] move_count;
    logic       locked;

    typedef struct {
        int         cyc;
        logic [3:0] dir;
    } pulse_t;

    pulse_t exp_q[$];
    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    int     model_count = 0;
    bit     model_locked = 1'b0;

    logic [3:0] pv_mon;
    pulse_t     p_mon;

    always #5 clock = ~clock;

    move_cmd_gen #(
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clock     (clock),
        .R         (R),
        .btn_n     (btn_n),
        .btn_s     (btn_s),
        .btn_e     (btn_e),
        .btn_w     (btn_w),
        .win       (win),
        .d         (d),
        .n         (n),
        .s         (s),
        .e         (e),
        .w         (w),
        .move_count(move_count),
        .locked    (locked)
    );

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic drive(input logic [3:0] v);
        {btn_n, btn_s, btn_e, btn_w} = v;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Hold a raw pattern for 'hold' sampling edges, then release for 'gap'.
    // A one-hot pattern seen on at least DEB+1 edges is one accepted move whose
    // pulse shows DEB+2 edges after the first edge that samples the press.
    task automatic press(input logic [3:0] pat, input int hold, input int gap);
        pulse_t p;
        step();
        drive(pat);
        if ($countones(pat) == 1 && hold >= DEB + 1 && !model_locked) begin
            p.cyc = cyc + 1 + DEB + 2;
            p.dir = pat;
            exp_q.push_back(p);
            if (model_count < 255) model_count++;
        end
        repeat (hold) step();
        drive(4'd0);
        repeat (gap) step();
    endtask

    task automatic checkpoint(input string tag);
        step();
        check({tag, "_count"}, move_count, model_count);
        check({tag, "_locked"}, locked, model_locked);
    endtask

    task automatic do_reset();
        R = 1'b1;
        exp_q.delete();
        model_count = 0;
        model_locked = 1'b0;
        repeat (2) step();
        R = 1'b0;
    endtask

    // Monitor: every pulse must match the oldest predicted one exactly.
    always @(negedge clock) begin
        pv_mon = {n, s, e, w};
        if (pv_mon != 4'd0) begin
            check("pulse_onehot", $countones(pv_mon), 1);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got %b at cycle %0d expected none", pv_mon, cyc);
            end else begin
                p_mon = exp_q.pop_front();
                check("pulse_dir", pv_mon, p_mon.dir);
                check("pulse_cycle", cyc, p_mon.cyc);
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
            p_mon = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL missing_pulse: got none by cycle %0d expected %b at cycle %0d",
                     cyc, p_mon.dir, p_mon.cyc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] multi_tab [8];
        logic [3:0] pat;
        int         sel;

        multi_tab = '{4'b1001, 4'b1100, 4'b0011, 4'b0110, 4'b0101, 4'b1010, 4'b1111, 4'b0111};

        do_reset();
        check("rst_pulses", {n, s, e, w}, 0);
        check("rst_count", move_count, 0);
        check("rst_locked", locked, 0);

        // Glitch shorter than the debounce window.
        press(4'b1000, 3, 3);
        checkpoint("glitch");

        // Held east button: one pulse at the nominal latency, nothing more.
        press(4'b0010, 20, 3);
        checkpoint("hold_e");

        // Two buttons together are rejected; a clean south press follows.
        press(4'b1001, 10, 3);
        press(4'b0100, 10, 3);
        checkpoint("reject_then_s");

        // Debounce boundary: DEB edges is too short, DEB+1 is enough.
        press(4'b0001, DEB, 3);
        press(4'b0001, DEB + 1, 2);
        checkpoint("deb_edge");

        // Reset sampled on the edge that would enter ISSUE aborts the move.
        step();
        drive(4'b0010);
        repeat (DEB + 2) step();
        R = 1'b1;
        drive(4'd0);
        model_count = 0;
        step();
        check("abort_pulses", {n, s, e, w}, 0);
        check("abort_count", move_count, 0);
        check("abort_locked", locked, 0);
        R = 1'b0;
        repeat (10) step();
        checkpoint("abort_after");

        // Game over via d freezes moves until reset.
        press(4'b1000, 8, 3);
        d = 1'b1;
        model_locked = 1'b1;
        step();
        d = 1'b0;
        press(4'b0001, 12, 3);
        checkpoint("locked_d");
        do_reset();
        checkpoint("locked_rst");

        // Saturation after 256 accepted moves.
        for (int i = 0; i < 256; i++) begin
            pat = 4'b0001 << (i % 4);
            press(pat, DEB + 1, 2);
        end
        checkpoint("saturate");

        // Randomized mix of presses, glitches and rejects, with a late win.
        do_reset();
        for (int i = 0; i < 120; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) pat = 4'd0;
            else if (sel <= 2) pat = multi_tab[$urandom_range(0, 7)];
            else pat = 4'b0001 << $urandom_range(0, 3);
            press(pat, $urandom_range(1, DEB + 4), $urandom_range(2, 5));
            if (i == 90) begin
                win = 1'b1;
                model_locked = 1'b1;
                step();
                win = 1'b0;
            end
            if (i % 10 == 9) checkpoint("rand");
        end

        repeat (5) step();
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
